mst_result_reporter: RTL and testbench



---
 rtl/mst_result_reporter.sv | 140 ++++++++++++++
 tb/tb_mst_result_reporter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mst_result_reporter.sv
// mst_result_reporter: snapshots the memory-system tester's four result
// counters on the rising edge of done and streams an 11-byte result frame
// (header, counters, status, XOR checksum) over a valid/ready byte link.
// Sticky pass/result_valid/overrun flags and a frame counter feed board LEDs.
module mst_result_reporter #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter logic [8:0] MAX_ATTEMPTS = 9'd256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       done,
  input  logic [8:0] t1attempts,
  input  logic [8:0] t1fails,
  input  logic [8:0] t2attempts,
  input  logic [8:0] t2fails,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       pass,
  output logic       result_valid,
  output logic       overrun,
  output logic [7:0] frames_sent
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DROP} state_t;

  typedef struct packed {
    logic [8:0] t1a;
    logic [8:0] t1f;
    logic [8:0] t2a;
    logic [8:0] t2f;
    logic       t1ok;
    logic       t2ok;
  } snap_t;

  state_t     state, state_nxt;
  snap_t      snap;
  logic       done_d;
  logic       start, capture, xfer, last, ovr_set;
  logic       t1ok_in, t2ok_in;
  logic [3:0] idx;
  logic [7:0] csum;
  logic [7:0] nxt_byte;

  assign start     = done & ~done_d;
  assign capture   = start & (state == IDLE);
  // A new edge while a frame is still owned is recorded but otherwise ignored.
  assign ovr_set   = start & (state != IDLE);
  assign xfer      = (state == SEND) & out_ready;
  assign last      = xfer & (idx == 4'd10);
  assign t1ok_in   = (t1fails == 9'd0) & (t1attempts == MAX_ATTEMPTS);
  assign t2ok_in   = (t2fails == 9'd0) & (t2attempts == MAX_ATTEMPTS);
  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);

  // State register and done edge-detect history.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      done_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_d <= done;
    end
  end

  // Next-state: a held done parks in WAIT_DROP so it is reported only once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = SEND;
      SEND:      if (last) state_nxt = done ? WAIT_DROP : IDLE;
      WAIT_DROP: if (!done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Byte that follows the one at idx; status picks up an overrun flagged on
  // the same edge, checksum folds in the byte currently leaving.
  always_comb begin
    nxt_byte = 8'h00;
    case (idx)
      4'd0:    nxt_byte = {7'b0, snap.t1a[8]};
      4'd1:    nxt_byte = snap.t1a[7:0];
      4'd2:    nxt_byte = {7'b0, snap.t1f[8]};
      4'd3:    nxt_byte = snap.t1f[7:0];
      4'd4:    nxt_byte = {7'b0, snap.t2a[8]};
      4'd5:    nxt_byte = snap.t2a[7:0];
      4'd6:    nxt_byte = {7'b0, snap.t2f[8]};
      4'd7:    nxt_byte = snap.t2f[7:0];
      4'd8:    nxt_byte = {5'b0, overrun | ovr_set, snap.t2ok, snap.t1ok};
      4'd9:    nxt_byte = csum ^ out_data;
      default: nxt_byte = 8'h00;
    endcase
  end

  // Snapshot and verdict, taken only on an accepted start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap         <= '0;
      pass         <= 1'b0;
      result_valid <= 1'b0;
    end else if (capture) begin
      snap         <= '{t1a: t1attempts, t1f: t1fails, t2a: t2attempts,
                        t2f: t2fails, t1ok: t1ok_in, t2ok: t2ok_in};
      pass         <= t1ok_in & t2ok_in;
      result_valid <= 1'b1;
    end
  end

  // Output byte register: only advances on a transfer, so it holds during stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= 4'd0;
      csum     <= 8'h00;
      out_data <= 8'h00;
    end else if (capture) begin
      idx      <= 4'd0;
      csum     <= 8'h00;
      out_data <= HEADER;
    end else if (xfer) begin
      idx      <= idx + 4'd1;
      csum     <= csum ^ out_data;
      out_data <= nxt_byte;
    end
  end

  // Sticky overrun and completed-frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun     <= 1'b0;
      frames_sent <= 8'h00;
    end else begin
      if (ovr_set) overrun <= 1'b1;
      if (last)    frames_sent <= frames_sent + 8'd1;
    end
  end

endmodule

// File: tb/tb_mst_result_reporter.sv
// tb_mst_result_reporter: drives tester-like results and randomized sink
// backpressure, collects transferred bytes and compares each frame and the
// sticky flags against a frame model built from the counter values.
module tb_mst_result_reporter;

  logic       clock = 1'b0;
  logic       reset, done, out_ready;
  logic [8:0] t1attempts, t1fails, t2attempts, t2fails;
  logic       out_valid, busy, pass, result_valid, overrun;
  logic [7:0] out_data, frames_sent;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got[$];

  // reference model state
  bit m_pass, m_rv, m_ovr;
  int m_frames;

  mst_result_reporter dut (
    .clock(clock), .reset(reset), .done(done),
    .t1attempts(t1attempts), .t1fails(t1fails),
    .t2attempts(t2attempts), .t2fails(t2fails),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .pass(pass), .result_valid(result_valid),
    .overrun(overrun), .frames_sent(frames_sent)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ok(input logic [8:0] a, input logic [8:0] f);
    return (f == 0) && (a == 256);
  endfunction

  // Compare the collected bytes with the frame derived from the counters.
  task automatic expect_frame(input string tag, input logic [8:0] a1, input logic [8:0] f1,
                              input logic [8:0] a2, input logic [8:0] f2, input bit ovr);
    logic [7:0] e[11];
    logic [7:0] x;
    e[0] = 8'hA5;
    e[1] = 8'(a1 / 256);  e[2] = 8'(a1 % 256);
    e[3] = 8'(f1 / 256);  e[4] = 8'(f1 % 256);
    e[5] = 8'(a2 / 256);  e[6] = 8'(a2 % 256);
    e[7] = 8'(f2 / 256);  e[8] = 8'(f2 % 256);
    e[9] = 8'(int'(ok(a1, f1)) + 2 * int'(ok(a2, f2)) + 4 * int'(ovr));
    x = 8'h00;
    for (int i = 0; i < 10; i++) x = x ^ e[i];
    e[10] = x;
    chk({tag, "_len"}, 32'(got.size()), 32'd11);
    for (int i = 0; i < 11 && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(e[i]));
  endtask

  task automatic note_frame(input logic [8:0] a1, input logic [8:0] f1,
                            input logic [8:0] a2, input logic [8:0] f2);
    m_pass   = ok(a1, f1) && ok(a2, f2);
    m_rv     = 1'b1;
    m_frames = (m_frames + 1) % 256;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_pass"},   32'(pass),         32'(m_pass));
    chk({tag, "_rv"},     32'(result_valid), 32'(m_rv));
    chk({tag, "_ovr"},    32'(overrun),      32'(m_ovr));
    chk({tag, "_frames"}, 32'(frames_sent),  32'(m_frames));
  endtask

  // Raise done, then run cycles: scramble counters, apply ready with rdy_pct
  // probability, collect transfers, optionally re-raise done or reset mid-frame.
  task automatic run_frame(input logic [8:0] a1, input logic [8:0] f1,
                           input logic [8:0] a2, input logic [8:0] f2,
                           input int hold, input int rdy_pct, input int rerise_at,
                           input int rst_at, output bit rerisen, output int last_push);
    int         dcnt;
    bit         stall, fin, rr, dlow;
    logic [7:0] pd;
    got.delete();
    rerisen = 0; last_push = 0; stall = 0; fin = 0; pd = 8'h00;
    @(negedge clock);
    t1attempts = a1; t1fails = f1; t2attempts = a2; t2fails = f2;
    done = 1'b1;
    dcnt = hold;
    for (int c = 1; c <= 600 && !fin; c++) begin
      @(negedge clock);
      if (c == 1) chk("latency", 32'(out_valid), 32'd1);
      if (stall) chk("stall_hold", 32'(out_data), 32'(pd));
      t1attempts = 9'($urandom); t1fails = 9'($urandom);
      t2attempts = 9'($urandom); t2fails = 9'($urandom);
      if (rst_at >= 0 && got.size() == rst_at) begin
        reset = 1'b1;
        done = 1'b0;
        out_ready = 1'b1;
        return;
      end
      dlow = !done;
      if (rerise_at >= 0 && !rerisen && dlow && got.size() == rerise_at) begin
        done = 1'b1; dcnt = 2; rerisen = 1;
      end else begin
        if (dcnt > 0) dcnt--;
        if (dcnt == 0) done = 1'b0;
      end
      rr = ($urandom_range(99) < rdy_pct);
      out_ready = rr;
      if (out_valid && rr) begin
        got.push_back(out_data);
        last_push = c;
      end
      stall = out_valid && !rr;
      pd = out_data;
      if (got.size() >= 11 && !out_valid && !busy && !done) fin = 1;
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; done = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_pass = 0; m_rv = 0; m_ovr = 0; m_frames = 0;
  endtask

  initial begin
    bit       rz;
    int       lp, hold, pct, rat;
    bit       ovr;
    logic [8:0] a1, f1, a2, f2;

    reset = 1'b1; done = 1'b0; out_ready = 1'b0;
    t1attempts = '0; t1fails = '0; t2attempts = '0; t2fails = '0;
    m_pass = 0; m_rv = 0; m_ovr = 0; m_frames = 0;
    repeat (3) @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    check_flags("rst");
    reset = 1'b0;

    // passing run, back-to-back
    run_frame(9'd256, 9'd0, 9'd256, 9'd0, 3, 100, -1, -1, rz, lp);
    expect_frame("passrun", 9'd256, 9'd0, 9'd256, 9'd0, 1'b0);
    chk("passrun_b2b", 32'(lp), 32'd11);
    chk("passrun_csum", 32'(got[10]), 32'hA6);
    note_frame(9'd256, 9'd0, 9'd256, 9'd0);
    check_flags("passrun");

    // failing run
    run_frame(9'd256, 9'd5, 9'd256, 9'd256, 3, 100, -1, -1, rz, lp);
    expect_frame("failrun", 9'd256, 9'd5, 9'd256, 9'd256, 1'b0);
    chk("failrun_csum", 32'(got[10]), 32'hA1);
    note_frame(9'd256, 9'd5, 9'd256, 9'd256);
    check_flags("failrun");

    // backpressure
    run_frame(9'd256, 9'd0, 9'd256, 9'd0, 3, 45, -1, -1, rz, lp);
    expect_frame("bp", 9'd256, 9'd0, 9'd256, 9'd0, 1'b0);
    note_frame(9'd256, 9'd0, 9'd256, 9'd0);
    check_flags("bp");

    // held done yields a single frame
    do_reset();
    run_frame(9'd256, 9'd0, 9'd256, 9'd0, 40, 100, -1, -1, rz, lp);
    expect_frame("held", 9'd256, 9'd0, 9'd256, 9'd0, 1'b0);
    note_frame(9'd256, 9'd0, 9'd256, 9'd0);
    check_flags("held");
    repeat (4) @(negedge clock);
    chk("held_noretrig", 32'(out_valid), 32'd0);

    // done re-raised at idx 4: overrun, frame unchanged
    run_frame(9'd256, 9'd3, 9'd256, 9'd0, 2, 100, 4, -1, rz, lp);
    chk("ovr_rerisen", 32'(rz), 32'd1);
    m_ovr = 1'b1;
    expect_frame("ovr2", 9'd256, 9'd3, 9'd256, 9'd0, 1'b1);
    note_frame(9'd256, 9'd3, 9'd256, 9'd0);
    check_flags("ovr2");
    run_frame(9'd256, 9'd0, 9'd256, 9'd0, 3, 100, -1, -1, rz, lp);
    expect_frame("ovr3", 9'd256, 9'd0, 9'd256, 9'd0, 1'b1);
    chk("ovr3_status_bit2", 32'(got[9][2]), 32'd1);
    note_frame(9'd256, 9'd0, 9'd256, 9'd0);
    check_flags("ovr3");

    // reset mid-frame at idx 6
    run_frame(9'd256, 9'd0, 9'd256, 9'd0, 3, 100, -1, 6, rz, lp);
    @(negedge clock);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy",  32'(busy),      32'd0);
    reset = 1'b0;
    m_pass = 0; m_rv = 0; m_ovr = 0; m_frames = 0;
    check_flags("midrst");
    run_frame(9'd256, 9'd0, 9'd256, 9'd0, 3, 100, -1, -1, rz, lp);
    expect_frame("fresh", 9'd256, 9'd0, 9'd256, 9'd0, 1'b0);
    note_frame(9'd256, 9'd0, 9'd256, 9'd0);
    check_flags("fresh");

    // incomplete run
    run_frame(9'd256, 9'd0, 9'd200, 9'd0, 3, 100, -1, -1, rz, lp);
    expect_frame("incomp", 9'd256, 9'd0, 9'd200, 9'd0, 1'b0);
    chk("incomp_status", 32'(got[9]), 32'h01);
    note_frame(9'd256, 9'd0, 9'd200, 9'd0);
    check_flags("incomp");

    // randomized frames; enough of them to wrap frames_sent
    for (int n = 0; n < 260; n++) begin
      a1 = ($urandom_range(9) < 6) ? 9'd256 : 9'($urandom);
      a2 = ($urandom_range(9) < 6) ? 9'd256 : 9'($urandom);
      f1 = ($urandom_range(9) < 6) ? 9'd0   : 9'($urandom);
      f2 = ($urandom_range(9) < 6) ? 9'd0   : 9'($urandom);
      hold = int'($urandom_range(1, 20));
      pct  = int'($urandom_range(30, 100));
      rat  = ($urandom_range(99) < 15) ? int'($urandom_range(1, 8)) : -1;
      run_frame(a1, f1, a2, f2, hold, pct, rat, -1, rz, lp);
      if (rz) m_ovr = 1'b1;
      ovr = m_ovr;
      expect_frame($sformatf("rnd%0d", n), a1, f1, a2, f2, ovr);
      note_frame(a1, f1, a2, f2);
      check_flags($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
